// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue unit: opcodes, flag bit positions and the
// response entry held in the response FIFO.
package alu_issue_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOTA = 4'd5,
        OP_NOTB = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9
    } alu_op_e;

    localparam logic [3:0] ALU_OP_LAST = 4'd9;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_NEG   = 3;

    // Widest tag the response entry can carry; narrower tags are zero-extended.
    localparam int TAG_W_MAX = 16;

    typedef struct packed {
        logic [31:0]          result;
        logic [3:0]           flags;
        logic                 err;
        logic [TAG_W_MAX-1:0] tag;
    } rsp_entry_t;

    function automatic logic op_illegal(input logic [3:0] op);
        return op > ALU_OP_LAST;
    endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Generic first-word-fall-through FIFO; the head entry is always visible on dout.
module alu_issue_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [7:0],
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  entry_t        din,
    input  logic          pop,
    output entry_t        dout,
    output logic          empty,
    output logic [CW-1:0] count
);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (count != CW'(DEPTH));
    assign dout    = mem[rd_ptr];

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue stage in front of the shared 32-bit ALU with a credit-checked response FIFO.
// Optional operand chaining from the previous result: define ALU_ISSUE_CHAIN_EN.
module alu_issue_unit
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
`ifdef ALU_ISSUE_CHAIN_EN
    input  logic             cmd_chain,
`endif
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_negative,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    input  logic             sticky_clr,
    output logic             sticky_carry,
    output logic             sticky_ovf
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // ready never depends on valid, and the producer holds payload while valid && !ready.
    logic             accept;
    logic             issue_valid;
    logic             issue_err;
    logic [3:0]       issue_op;
    logic [31:0]      issue_a;
    logic [31:0]      issue_b;
    logic [TAG_W-1:0] issue_tag;
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    occupancy;
    logic             fifo_empty;
    rsp_entry_t       push_entry;
    rsp_entry_t       head;
    logic             unused_head_tag;

    // Credit counts the op in flight so the FIFO can never be pushed while full.
    assign occupancy = fifo_count + CW'(issue_valid);
    assign cmd_ready = (occupancy < CW'(DEPTH));
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid <= 1'b0;
            issue_err   <= 1'b0;
            issue_op    <= '0;
            issue_a     <= '0;
            issue_b     <= '0;
            issue_tag   <= '0;
        end else begin
            issue_valid <= accept;
            if (accept) begin
                issue_err <= op_illegal(cmd_op);
                issue_op  <= cmd_op;
                issue_a   <= cmd_a;
                issue_b   <= cmd_b;
                issue_tag <= cmd_tag;
            end
        end
    end

`ifdef ALU_ISSUE_CHAIN_EN
    logic        issue_chain;
    logic [31:0] last_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_chain <= 1'b0;
            last_result <= '0;
        end else begin
            if (accept) begin
                issue_chain <= cmd_chain;
            end
            if (issue_valid) begin
                last_result <= alu_result;
            end
        end
    end

    assign alu_a = issue_chain ? last_result : issue_a;
`else
    assign alu_a = issue_a;
`endif
    assign alu_b  = issue_b;
    assign alu_op = issue_op;

    always_comb begin
        push_entry                   = '0;
        push_entry.result            = alu_result;
        push_entry.flags[FLAG_ZERO]  = alu_zero;
        push_entry.flags[FLAG_CARRY] = alu_carry;
        push_entry.flags[FLAG_OVF]   = alu_overflow;
        push_entry.flags[FLAG_NEG]   = alu_negative;
        push_entry.err               = issue_err;
        push_entry.tag               = TAG_W_MAX'(issue_tag);
    end

    alu_issue_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (rsp_entry_t)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue_valid),
        .din   (push_entry),
        .pop   (rsp_ready),
        .dout  (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rsp_valid       = !fifo_empty;
    assign rsp_result      = head.result;
    assign rsp_flags       = head.flags;
    assign rsp_err         = head.err;
    assign rsp_tag         = head.tag[TAG_W-1:0];
    assign unused_head_tag = ^head.tag;

    // A set arriving with a clear wins; illegal ops never touch sticky status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_carry <= 1'b0;
            sticky_ovf   <= 1'b0;
        end else begin
            sticky_carry <= (issue_valid && !issue_err && alu_carry)
                            || (sticky_carry && !sticky_clr);
            sticky_ovf   <= (issue_valid && !issue_err && alu_overflow)
                            || (sticky_ovf && !sticky_clr);
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural ALU, command driver, response scoreboard.
module tb_alu_issue_unit;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int EW    = 32 + 4 + 1 + TAG_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_op = '0;
    logic [31:0]      cmd_a = '0;
    logic [31:0]      cmd_b = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
`ifdef ALU_ISSUE_CHAIN_EN
    logic             cmd_chain = 1'b0;
`endif
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_op;
    logic [31:0]      alu_result;
    logic             alu_zero;
    logic             alu_carry;
    logic             alu_overflow;
    logic             alu_negative;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_result;
    logic [3:0]       rsp_flags;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;
    logic             sticky_clr = 1'b0;
    logic             sticky_carry;
    logic             sticky_ovf;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [EW-1:0]    exp_q[$];
    logic [31:0]      model_last = '0;
    logic [35:0]      alu_out;

    alu_issue_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_tag      (cmd_tag),
`ifdef ALU_ISSUE_CHAIN_EN
        .cmd_chain    (cmd_chain),
`endif
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .alu_negative (alu_negative),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .rsp_err      (rsp_err),
        .rsp_tag      (rsp_tag),
        .sticky_clr   (sticky_clr),
        .sticky_carry (sticky_carry),
        .sticky_ovf   (sticky_ovf)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Returns {neg, ovf, carry, zero, result}. Undefined opcodes give a zero
    // result but raise carry and overflow so any sticky leak is visible.
    function automatic logic [35:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c;
        logic        v;
        w = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: begin
                r = a - b;
                c = (a < b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = ~a;
            4'd6:    r = ~b;
            4'd7:    r = a << b[4:0];
            4'd8:    r = a >> b[4:0];
            4'd9:    r = $signed(a) >>> b[4:0];
            default: begin r = '0; c = 1'b1; v = 1'b1; end
        endcase
        return {r[31], v, c, (r == 32'd0), r};
    endfunction

    assign alu_out      = alu_model(alu_op, alu_a, alu_b);
    assign alu_result   = alu_out[31:0];
    assign alu_zero     = alu_out[32];
    assign alu_carry    = alu_out[33];
    assign alu_overflow = alu_out[34];
    assign alu_negative = alu_out[35];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic push_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] tag, input logic chain);
        logic [31:0] a_eff;
        logic [35:0] m;
        a_eff = chain ? model_last : a;
        m = alu_model(op, a_eff, b);
        exp_q.push_back({m[31:0], m[35:32], (op > 4'd9), tag});
        model_last = m[31:0];
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                check_eq("rsp_payload", 64'({rsp_result, rsp_flags, rsp_err, rsp_tag}),
                         64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic chain);
        int waited = 0;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
`ifdef ALU_ISSUE_CHAIN_EN
        cmd_chain = chain;
`endif
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 200) begin
            if (waited > 2) rsp_ready = 1'b1;
            @(posedge clk); #1;
            waited++;
        end
        if (!cmd_ready) begin
            check_eq("send_timeout", 64'(cmd_ready), 64'(1));
            cmd_valid = 1'b0;
            return;
        end
        push_exp(op, a, b, tag, chain);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || rsp_valid) && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check_eq("drain_left", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1);
    end

    initial begin
        int accepts;
        logic [3:0] op;

        // ---------------- reset ----------------
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check_eq("rst_alu_ops", 64'({alu_op, alu_a, alu_b} != '0), 64'(0));
        check_eq("rst_rsp_fields", 64'({rsp_result, rsp_flags, rsp_err, rsp_tag}), 64'(0));
        check_eq("rst_sticky", 64'({sticky_carry, sticky_ovf}), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // ADD with carry out: latency two edges, flags carry+zero
        rsp_ready = 1'b1;
        send(4'd0, 32'hFFFF_FFFF, 32'd1, 4'd1, 1'b0);
        check_eq("add_lat_not_yet", 64'(rsp_valid), 64'(0));
        @(posedge clk); #1;
        check_eq("add_rsp_valid", 64'(rsp_valid), 64'(1));
        check_eq("add_result", 64'(rsp_result), 64'(0));
        check_eq("add_flags", 64'(rsp_flags), 64'(4'b0011));
        check_eq("add_sticky_c", 64'(sticky_carry), 64'(1));
        wait_drain();

        // SUB signed overflow with tag 5
        send(4'd1, 32'h8000_0000, 32'd1, 4'd5, 1'b0);
        @(posedge clk); #1;
        check_eq("sub_result", 64'(rsp_result), 64'(32'h7FFF_FFFF));
        check_eq("sub_flags", 64'(rsp_flags), 64'(4'b0100));
        check_eq("sub_tag", 64'(rsp_tag), 64'(5));
        check_eq("sub_sticky_v", 64'(sticky_ovf), 64'(1));
        wait_drain();

        // sticky clear, then illegal opcode must not set sticky
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        check_eq("clr_sticky", 64'({sticky_carry, sticky_ovf}), 64'(0));
        send(4'hC, 32'd1, 32'd2, 4'd7, 1'b0);
        @(posedge clk); #1;
        check_eq("ill_err", 64'(rsp_err), 64'(1));
        check_eq("ill_result", 64'(rsp_result), 64'(0));
        check_eq("ill_sticky", 64'({sticky_carry, sticky_ovf}), 64'(0));
        wait_drain();

        // clear coinciding with a carry-setting push: set wins
        send(4'd0, 32'hFFFF_FFFF, 32'd2, 4'd8, 1'b0);
        send(4'd0, 32'hFFFF_FFFF, 32'd3, 4'd9, 1'b0);
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        check_eq("clr_set_wins", 64'(sticky_carry), 64'(1));
        wait_drain();

        // credit: stream 8 commands against a stalled response channel
        rsp_ready = 1'b0;
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_op    = 4'($urandom_range(0, 9));
            cmd_a     = $urandom;
            cmd_b     = $urandom;
            cmd_tag   = TAG_W'(i);
            cmd_valid = 1'b1;
            if (cmd_ready) begin
                push_exp(cmd_op, cmd_a, cmd_b, cmd_tag, 1'b0);
                accepts++;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check_eq("credit_accepts", 64'(accepts), 64'(DEPTH));
        check_eq("credit_ready_low", 64'(cmd_ready), 64'(0));
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_payload", 64'({rsp_result, rsp_flags, rsp_err, rsp_tag}),
                     64'(exp_q[0]));
            @(posedge clk); #1;
        end
        wait_drain();

        // randomized traffic with random response back-pressure
        for (int i = 0; i < 30; i++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            op = 4'($urandom_range(0, 11));
            send(op, $urandom, 32'($urandom_range(0, 40)), TAG_W'($urandom), 1'b0);
        end
        wait_drain();

`ifdef ALU_ISSUE_CHAIN_EN
        // chained SLL picks up the preceding ADD result with no bubble
        send(4'd0, 32'd2, 32'd3, 4'd1, 1'b0);
        send(4'd7, 32'hDEAD_0000, 32'd4, 4'd2, 1'b1);
        check_eq("chain_model", 64'(model_last), 64'(32'h50));
        wait_drain();
`endif

        // reset with 3 queued responses and one op in issue
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(4'd3, 32'h10 + 32'(i), 32'h1, TAG_W'(i), 1'b0);
        end
        check_eq("pre_rst_full", 64'(cmd_ready), 64'(0));
        rst = 1'b1;
        #1;
        check_eq("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
        check_eq("midrst_alu_a", 64'(alu_a), 64'(0));
        exp_q.delete();
        model_last = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("no_stale_rsp", 64'(rsp_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
